// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding req/ack handshake to
// instruction memory and feeds decode through a stall-holding output slot.
// Optional HALT detection is compiled in with `define FETCH_HALT_DETECT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | normal fetching; request whenever the output slot can accept
// S_SQUASH | redirected mid-handshake; finish old request, discard its data
// S_HALTED | HALT delivered; no further requests until redirect or reset
module fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_ack,
    output logic [15:0] instruc,
    output logic [15:0] seq_PC,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_SQUASH = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] tgt;
    logic [15:0] slot_instr;
    logic [15:0] slot_seq;
    logic        slot_valid;

    logic        slot_free;
    logic        ack_ok;
    logic        is_halt;
    logic [15:0] pc_plus2;

    assign slot_free = !slot_valid || !stall;
    assign pc_plus2  = pc + 16'd2;

    // An ack without a pending request is a protocol violation and is ignored.
    assign ack_ok = imem_ack && imem_req;

`ifdef FETCH_HALT_DETECT_EN
    assign is_halt = (imem_data[15:11] == 5'b00000);
    assign halted  = (state == S_HALTED);
`else
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    always_comb begin
        imem_req = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH:  imem_req = slot_free;
                S_SQUASH: imem_req = 1'b1;
                default:  imem_req = 1'b0;
            endcase
        end
    end

    // In SQUASH the old pc stays on the bus so the address never moves mid-handshake.
    assign imem_addr   = pc;
    assign instruc     = slot_valid ? slot_instr : NOP_INSTR;
    assign seq_PC      = slot_seq;
    assign instr_valid = slot_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            tgt        <= 16'h0000;
            slot_instr <= NOP_INSTR;
            slot_seq   <= 16'h0000;
            slot_valid <= 1'b0;
        end else if (redirect) begin
            slot_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
                // Request still outstanding: let it complete, then jump.
                tgt   <= redirect_pc;
                state <= S_SQUASH;
            end else begin
                pc    <= redirect_pc;
                state <= S_FETCH;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (ack_ok) begin
                        slot_instr <= imem_data;
                        slot_seq   <= pc_plus2;
                        slot_valid <= 1'b1;
                        if (is_halt) begin
                            state <= S_HALTED;
                        end else begin
                            pc <= pc_plus2;
                        end
                    end else if (!stall) begin
                        slot_valid <= 1'b0;
                    end
                end
                S_SQUASH: begin
                    if (!stall) begin
                        slot_valid <= 1'b0;
                    end
                    if (ack_ok) begin
                        pc    <= tgt;
                        state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (!stall) begin
                        slot_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: memory responses are driven step by step with
// hand-computed expectations for every checked output.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_ack;
    logic [15:0] instruc;
    logic [15:0] seq_PC;
    logic        instr_valid;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_ack   (imem_ack),
        .instruc    (instruc),
        .seq_PC     (seq_PC),
        .instr_valid(instr_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; applies inputs for one cycle and returns at the next negedge.
    // ackm: 0 none, 1 ack-if-req with d, 2 ack-if-req with addr as data, 3 forced ack with d
    task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                        input int ackm, input logic [15:0] d);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        case (ackm)
            1: begin imem_ack = imem_req; imem_data = d;         end
            2: begin imem_ack = imem_req; imem_data = imem_addr; end
            3: begin imem_ack = 1'b1;     imem_data = d;         end
            default: begin imem_ack = 1'b0; imem_data = 16'h0000; end
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_ack    = 1'b0;
        imem_data   = 16'h0000;

        repeat (2) @(negedge clk);
        chk("rst_req",    {15'd0, imem_req},    16'h0000);
        chk("rst_valid",  {15'd0, instr_valid}, 16'h0000);
        chk("rst_instr",  instruc,              16'h0800);
        chk("rst_seq",    seq_PC,               16'h0000);
        chk("rst_halted", {15'd0, halted},      16'h0000);

        rst_n = 1'b1;
        #1;
        chk("first_req",  {15'd0, imem_req}, 16'h0001);
        chk("first_addr", imem_addr,         16'h0000);

        // Zero-wait memory, addr-as-data: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'h0000, 2, 16'h0000);
            chk("stream_instr", instruc,              16'(2 * i));
            chk("stream_seq",   seq_PC,               16'(2 * i + 2));
            chk("stream_valid", {15'd0, instr_valid}, 16'h0001);
        end

        // Load 0x1234 from 0x0008, then stall 3 cycles with a stray ack.
        step(1'b0, 1'b0, 16'h0000, 1, 16'h1234);
        chk("ld_instr", instruc, 16'h1234);
        chk("ld_seq",   seq_PC,  16'h000A);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            chk("stall_req", {15'd0, imem_req}, 16'h0000);
            step(1'b1, 1'b0, 16'h0000, 3, 16'hBEEF);
            chk("stall_instr", instruc,              16'h1234);
            chk("stall_valid", {15'd0, instr_valid}, 16'h0001);
        end
        stall = 1'b0;
        #1;
        chk("unstall_req",  {15'd0, imem_req}, 16'h0001);
        chk("unstall_addr", imem_addr,         16'h000A);
        step(1'b0, 1'b0, 16'h0000, 2, 16'h0000);
        chk("unstall_instr", instruc, 16'h000A);
        chk("unstall_seq",   seq_PC,  16'h000C);

        // Slow memory: redirect to 0x0100 while the request at 0x000C is pending.
        step(1'b0, 1'b0, 16'h0000, 0, 16'h0000);
        chk("wait_valid", {15'd0, instr_valid}, 16'h0000);
        chk("wait_addr",  imem_addr,            16'h000C);
        step(1'b0, 1'b1, 16'h0100, 0, 16'h0000);
        chk("sq_valid", {15'd0, instr_valid}, 16'h0000);
        chk("sq_req",   {15'd0, imem_req},    16'h0001);
        chk("sq_addr",  imem_addr,            16'h000C);
        step(1'b0, 1'b0, 16'h0000, 0, 16'h0000);
        chk("sq_addr_hold", imem_addr, 16'h000C);
        step(1'b0, 1'b0, 16'h0000, 1, 16'hDEAD);
        chk("sq_done_valid", {15'd0, instr_valid}, 16'h0000);
        chk("sq_done_instr", instruc,              16'h0800);
        chk("sq_done_addr",  imem_addr,            16'h0100);
        chk("sq_done_req",   {15'd0, imem_req},    16'h0001);

        // Redirect coincident with ack: go to 0x0040, then redirect again on its ack.
        step(1'b0, 1'b1, 16'h0040, 1, 16'h7777);
        chk("rd40_addr",  imem_addr,            16'h0040);
        chk("rd40_valid", {15'd0, instr_valid}, 16'h0000);
        step(1'b0, 1'b1, 16'h0200, 2, 16'h0000);
        chk("rdack_addr",  imem_addr,            16'h0200);
        chk("rdack_valid", {15'd0, instr_valid}, 16'h0000);
        chk("rdack_instr", instruc,              16'h0800);

        // PC wrap at 0xFFFE.
        step(1'b0, 1'b1, 16'hFFFE, 2, 16'h0000);
        chk("wrap_addr0", imem_addr, 16'hFFFE);
        step(1'b0, 1'b0, 16'h0000, 1, 16'h5555);
        chk("wrap_instr", instruc,   16'h5555);
        chk("wrap_seq",   seq_PC,    16'h0000);
        chk("wrap_addr1", imem_addr, 16'h0000);

        // HALT word fetched at 0x0010.
        step(1'b0, 1'b1, 16'h0010, 1, 16'h7777);
        chk("h_addr", imem_addr, 16'h0010);
        step(1'b0, 1'b0, 16'h0000, 1, 16'h0000);
        chk("h_instr", instruc,              16'h0000);
        chk("h_seq",   seq_PC,               16'h0012);
        chk("h_valid", {15'd0, instr_valid}, 16'h0001);
`ifdef FETCH_HALT_DETECT_EN
        chk("h_halted", {15'd0, halted},   16'h0001);
        chk("h_req",    {15'd0, imem_req}, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 16'h0000, 2, 16'h0000);
            chk("h_drain_valid", {15'd0, instr_valid}, 16'h0000);
            chk("h_drain_instr", instruc,              16'h0800);
            chk("h_drain_req",   {15'd0, imem_req},    16'h0000);
            chk("h_drain_halt",  {15'd0, halted},      16'h0001);
        end
        step(1'b0, 1'b1, 16'h0020, 0, 16'h0000);
        chk("h_resume_halt", {15'd0, halted},   16'h0000);
        chk("h_resume_req",  {15'd0, imem_req}, 16'h0001);
        chk("h_resume_addr", imem_addr,         16'h0020);
        step(1'b0, 1'b0, 16'h0000, 2, 16'h0000);
        chk("h_resume_instr", instruc, 16'h0020);
`else
        chk("nh_halted", {15'd0, halted},   16'h0000);
        chk("nh_req",    {15'd0, imem_req}, 16'h0001);
        chk("nh_addr",   imem_addr,         16'h0012);
        step(1'b0, 1'b0, 16'h0000, 2, 16'h0000);
        chk("nh_instr", instruc, 16'h0012);
        chk("nh_seq",   seq_PC,  16'h0014);
`endif

        // Reset mid-handshake drops the request and empties the slot.
        step(1'b0, 1'b0, 16'h0000, 0, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("rst2_req",   {15'd0, imem_req},    16'h0000);
        chk("rst2_valid", {15'd0, instr_valid}, 16'h0000);
        chk("rst2_instr", instruc,              16'h0800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the 16-bit single-issue pipeline, directly upstream of decode. It owns the PC register and issues one word request at a time to instruction memory over a req/ack handshake. It presents the fetched instruction and PC+2 to decode through a registered output slot that holds its contents under stall. Taken branches and jumps redirect it. With halt detection compiled in, it stops fetching after delivering a HALT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, value driven on `instruc` whenever the slot is empty.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decode cannot accept this cycle; hold the output slot.
- redirect  in  1  taken branch or jump; flush the slot and refetch.
- redirect_pc  in  16  target address; sampled when `redirect`=1.
- imem_req  out  1  fetch request; held until `imem_ack`.
- imem_addr  out  16  word address of the request; stable while `imem_req`=1.
- imem_data  in  16  instruction word; valid when `imem_ack`=1.
- imem_ack  in  1  memory returns data this cycle.
- instruc  out  16  instruction to decode.
- seq_PC  out  16  fetched address + 2, mod 2^16.
- instr_valid  out  1  output slot holds a live instruction.
- halted  out  1  fetch stopped on HALT.

## Operation
- Registers:
  - `pc`
  - `tgt`: pending redirect target
  - output slot: `instruc`, `seq_PC`, `instr_valid`
  - FSM state: FETCH, SQUASH, HALTED
- `slot_free` = !instr_valid | !stall.
- FETCH:
  - `imem_req` = `slot_free`; `imem_addr` = `pc`.
  - On ack with no redirect: slot ← {imem_data, pc+2, 1}; `pc` ← `pc`+2.
  - No ack and `slot_free` & !stall: `instr_valid` ← 0.
  - Stall with a valid slot: slot unchanged and no request.
- Redirect, which has priority over every other event:
  - `instr_valid` ← 0.
  - If in FETCH with `imem_req`=1 and no ack the same cycle: the request is still outstanding. `tgt` ← `redirect_pc`, go to SQUASH.
  - Otherwise: `pc` ← `redirect_pc`, stay in or enter FETCH, and discard any ack data this cycle.
- SQUASH:
  - `imem_req`=1, `imem_addr`=old `pc`; the address is not changed mid-handshake.
  - On ack: data discarded, `pc` ← `tgt`, go to FETCH.
  - Another redirect while in SQUASH overwrites `tgt`; the last one wins.
- HALTED (FETCH_HALT_DETECT_EN only):
  - `imem_req`=0, `halted`=1.
  - The slot drains normally, so the HALT is delivered once.
  - Redirect → `pc` ← `redirect_pc`, `halted` ← 0, FETCH. This squashes a HALT fetched down a wrong path.
  - Exit is otherwise only by reset.
- An ack while `imem_req`=0 is a protocol violation and is ignored.
- PC arithmetic is 16-bit unsigned. 16'hFFFE + 2 = 16'h0000 with no flag.
- Empty slot drives `instruc` = NOP_INSTR. `seq_PC` keeps its last value.

## Timing
- Reset (async, while `rst_n`=0):
  - `pc`=RESET_PC, `tgt`=0, state FETCH.
  - `instr_valid`=0, `instruc`=NOP_INSTR, `seq_PC`=16'h0000, `halted`=0.
  - `imem_req` forced 0 while in reset.
- First request: the cycle after `rst_n` rises, `imem_req`=1 with `imem_addr`=RESET_PC.
- Memory may ack in the same cycle as `req` (combinational memory) or any later cycle.
- Latency: ack in cycle N → `instruc`/`instr_valid` visible in cycle N+1.
- Throughput: one instruction per cycle with a zero-wait memory and no stall.
- Redirect in cycle N:
  - `instr_valid`=0 in N+1.
  - First target request in N+1, or the cycle after the squashed ack.
- Reset mid-handshake abandons the request. Memory must tolerate `req` dropping.

## Configuration
- `FETCH_HALT_DETECT_EN` defined: on an accepted ack with `imem_data[15:11]`=5'b00000 and no redirect:
  - the word is loaded into the slot as usual;
  - `pc` is not incremented;
  - state → HALTED.
- `FETCH_HALT_DETECT_EN` undefined:
  - HALT is treated as an ordinary instruction and fetching continues;
  - HALTED is unreachable;
  - `halted` is tied 0.

## Test plan
- Reset, zero-wait memory returning addr-as-data, no stall → `instruc` = 0x0000, 0x0002, 0x0004… on consecutive cycles; `seq_PC` = data+2; `instr_valid` high from cycle 2.
- Stall for 3 cycles while slot holds 0x1234 → `instruc` stays 0x1234, `imem_req`=0, nothing lost; next word appears the cycle after stall drops.
- 3-cycle memory, redirect to 0x0100 one cycle after `req`:
  - `imem_addr` held until ack and that data discarded;
  - next request at 0x0100;
  - no stale instruction goes valid.
- Redirect coincident with ack at 0x0040 → data discarded, next request 0x0200 (target), `instr_valid`=0 next cycle.
- `pc`=0xFFFE → following request at 0x0000, `seq_PC`=0x0000.
- With FETCH_HALT_DETECT_EN, HALT (0x0000) fetched at 0x0010:
  - delivered once with `seq_PC`=0x0012;
  - `halted`=1 and `imem_req`=0 thereafter;
  - a redirect to 0x0020 resumes fetching.
- Without the macro, the same stimulus continues fetching at 0x0012.
